branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter OFFSET_SHIFT, default 2, left shift applied to br_offset when forming the target.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; reset is asynchronous and active-low (rst_n).
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: br_valid in 1 ID stage holds a branch; br_type in 3 branch kind; pc_plus4 in 32; br_offset in 32 sign-extended immediate.
REQ-005 SHALL have ports: rs_data in 32; rt_data in 32; rs_pending in 1; rt_pending in 1 (operand not yet forwardable); kill in 1 (flush from a later stage).
REQ-006 SHALL have ports: cmp_op1 out 32; cmp_op2 out 32; cmp_operation out 3; cmp_res in 1 (drives and reads the external comparator).
REQ-007 SHALL have ports: stall out 1; redirect out 1; redirect_pc out 32; br_err out 1; stat_branches out 32; stat_taken out 32.

Function
REQ-008 SHALL decode br_type: 000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ; 110/111 are invalid.
REQ-009 SHALL treat rt as needed only for BEQ/BNE; rt_pending SHALL be ignored for the other types.
REQ-010 SHALL implement FSM states IDLE, WAIT, EVAL.
REQ-011 In IDLE with br_valid=1 and any needed operand pending, SHALL go to WAIT.
REQ-012 In IDLE with br_valid=1 and no needed operand pending, SHALL capture rs, rt, type and target, then go to EVAL.
REQ-013 In WAIT, SHALL capture on the first cycle with no needed operand pending, then go to EVAL.
REQ-014 EVAL SHALL last exactly one cycle, then return to IDLE.
REQ-015 Target SHALL be pc_plus4 + (br_offset << OFFSET_SHIFT), computed modulo 2^32 at capture.
REQ-016 cmp_operation SHALL be constant 000 (equality).
REQ-017 cmp_op1 SHALL be captured rs; cmp_op2 SHALL be captured rt for BEQ/BNE, else 0.
REQ-018 Taken SHALL be: BEQ res; BNE !res; BLEZ rs[31]|res; BGTZ !rs[31]&!res; BLTZ rs[31]; BGEZ !rs[31] (res=cmp_res, rs=captured rs).
REQ-019 stall SHALL be combinational: (IDLE & br_valid) | WAIT; it SHALL be 0 in EVAL so the branch leaves ID at the end of EVAL.
REQ-020 redirect SHALL be combinational: EVAL & taken & !kill; redirect_pc SHALL equal the captured target whenever redirect=1, and hold its last value otherwise.
REQ-021 br_err SHALL pulse for one cycle in EVAL for an invalid type; an invalid type SHALL be not taken.
REQ-022 kill=1 in WAIT or EVAL SHALL abort to IDLE next cycle with no redirect; kill=1 in IDLE SHALL suppress the capture and the WAIT transition.
REQ-023 Minimum latency SHALL be 2 cycles from br_valid to the redirect decision: the capture cycle plus EVAL.
REQ-024 Back-to-back branches SHALL be accepted: a br_valid in the IDLE cycle after EVAL starts a new resolution.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE and clear the captured regs, redirect_pc and stat counters to 0.
REQ-026 While in reset, stall, redirect and br_err SHALL be 0; assertion mid-WAIT or mid-EVAL SHALL discard the branch.

Configuration
REQ-027 With macro BRANCH_UNIT_STATS_EN defined, each completed EVAL without kill SHALL increment stat_branches, and each redirect SHALL increment stat_taken.
REQ-028 The stat counters SHALL saturate at 0xFFFFFFFF; without the macro, both ports SHALL exist and be tied to 0.

Verification
REQ-029 BEQ, rs=rt=0x1234, pc_plus4=0x100, offset=0x10, no pending -> stall 1 cycle, redirect=1 with redirect_pc=0x140 in cycle 2.
REQ-030 BNE, rs=rt=5 -> no redirect in EVAL, return to IDLE; a following BGEZ rs=0 -> redirect.
REQ-031 BGTZ, rs=0x80000000, rs_pending high 3 cycles -> stall 4 cycles, EVAL not taken; BLEZ with rs=0 -> taken.
REQ-032 BEQ with kill asserted in EVAL -> redirect=0, stat_taken unchanged; kill in WAIT -> IDLE next cycle.
REQ-033 br_type=111 -> br_err pulses once, no redirect; rst_n low mid-WAIT -> stall=0 and IDLE immediately.
REQ-034 With BRANCH_UNIT_STATS_EN, 3 branches with 2 taken -> stat_branches=3, stat_taken=2; preload near saturation -> counters hold at 0xFFFFFFFF.

Source files
------------

// File: rtl/branch_unit.sv
// Branch resolution unit: waits for branch operands, drives an external equality
// comparator, and decides the redirect. Optional counters: BRANCH_UNIT_STATS_EN.
module branch_unit #(
   parameter int unsigned OFFSET_SHIFT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_valid,
   input  logic [2:0]  br_type,
   input  logic [31:0] pc_plus4,
   input  logic [31:0] br_offset,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        rs_pending,
   input  logic        rt_pending,
   input  logic        kill,
   output logic [31:0] cmp_op1,
   output logic [31:0] cmp_op2,
   output logic [2:0]  cmp_operation,
   input  logic        cmp_res,
   output logic        stall,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        br_err,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_taken
);

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLEZ = 3'b010;
   localparam logic [2:0] BR_BGTZ = 3'b011;
   localparam logic [2:0] BR_BLTZ = 3'b100;
   localparam logic [2:0] BR_BGEZ = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      EVAL = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] rs_q, rs_d;
   logic [31:0] rt_q, rt_d;
   logic [2:0]  type_q, type_d;
   logic [31:0] target_q, target_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        need_rt_s;
   logic        pending_s;
   logic        capture_s;
   logic        taken_s;
   logic        invalid_s;

   // Next-state and operand capture
   always_comb begin
      need_rt_s = (br_type == BR_BEQ) || (br_type == BR_BNE);
      pending_s = rs_pending | (need_rt_s & rt_pending);
      state_d   = state_q;
      capture_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (br_valid && !kill) begin
               if (pending_s) begin
                  state_d = WAIT;
               end else begin
                  capture_s = 1'b1;
                  state_d   = EVAL;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (kill) begin
               state_d = IDLE;
            end else if (!pending_s) begin
               capture_s = 1'b1;
               state_d   = EVAL;
            end else begin
               state_d = WAIT;
            end
         end
         EVAL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (capture_s) begin
         rs_d     = rs_data;
         rt_d     = need_rt_s ? rt_data : 32'd0;
         type_d   = br_type;
         target_d = pc_plus4 + (br_offset << OFFSET_SHIFT);
      end else begin
         rs_d     = rs_q;
         rt_d     = rt_q;
         type_d   = type_q;
         target_d = target_q;
      end
   end

   // Branch condition from the captured operands and the comparator result
   always_comb begin
      taken_s   = 1'b0;
      invalid_s = 1'b0;
      case (type_q)
         BR_BEQ:  taken_s = cmp_res;
         BR_BNE:  taken_s = ~cmp_res;
         BR_BLEZ: taken_s = rs_q[31] | cmp_res;
         BR_BGTZ: taken_s = ~rs_q[31] & ~cmp_res;
         BR_BLTZ: taken_s = rs_q[31];
         BR_BGEZ: taken_s = ~rs_q[31];
         default: invalid_s = 1'b1;
      endcase
   end

   // Pipeline-facing outputs; forced quiet while reset is held
   always_comb begin
      stall         = rst_n & (((state_q == IDLE) & br_valid) | (state_q == WAIT));
      redirect      = rst_n & (state_q == EVAL) & taken_s & ~kill;
      br_err        = rst_n & (state_q == EVAL) & invalid_s;
      redirect_pc_d = redirect ? target_q : redirect_pc_q;
      redirect_pc   = redirect_pc_d;
      cmp_op1       = rs_q;
      cmp_op2       = rt_q;
      cmp_operation = 3'b000;
   end

   // State and captured-operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rs_q          <= 32'd0;
         rt_q          <= 32'd0;
         type_q        <= 3'd0;
         target_q      <= 32'd0;
         redirect_pc_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         rs_q          <= rs_d;
         rt_q          <= rt_d;
         type_q        <= type_d;
         target_q      <= target_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

`ifdef BRANCH_UNIT_STATS_EN
   logic [31:0] stat_branches_q, stat_branches_d;
   logic [31:0] stat_taken_q, stat_taken_d;

   // Saturating counters: completed evaluations and redirects
   always_comb begin
      if ((state_q == EVAL) && !kill && (stat_branches_q != 32'hFFFF_FFFF)) begin
         stat_branches_d = stat_branches_q + 32'd1;
      end else begin
         stat_branches_d = stat_branches_q;
      end
      if (redirect && (stat_taken_q != 32'hFFFF_FFFF)) begin
         stat_taken_d = stat_taken_q + 32'd1;
      end else begin
         stat_taken_d = stat_taken_q;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches_q <= 32'd0;
         stat_taken_q    <= 32'd0;
      end else begin
         stat_branches_q <= stat_branches_d;
         stat_taken_q    <= stat_taken_d;
      end
   end

   assign stat_branches = stat_branches_q;
   assign stat_taken    = stat_taken_q;
`else
   assign stat_branches = 32'd0;
   assign stat_taken    = 32'd0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them.
module tb_branch_unit;

   logic        clk;
   logic        rst_n;
   logic        br_valid;
   logic [2:0]  br_type;
   logic [31:0] pc_plus4;
   logic [31:0] br_offset;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        rs_pending;
   logic        rt_pending;
   logic        kill;
   logic [31:0] cmp_op1;
   logic [31:0] cmp_op2;
   logic [2:0]  cmp_operation;
   logic        cmp_res;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        br_err;
   logic [31:0] stat_branches;
   logic [31:0] stat_taken;

   typedef struct {
      int          id;
      logic        stall;
      logic        redir;
      logic [31:0] pc;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc_id   = 0;

   branch_unit #(.OFFSET_SHIFT(2)) dut (
      .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_type(br_type),
      .pc_plus4(pc_plus4), .br_offset(br_offset), .rs_data(rs_data),
      .rt_data(rt_data), .rs_pending(rs_pending), .rt_pending(rt_pending),
      .kill(kill), .cmp_op1(cmp_op1), .cmp_op2(cmp_op2),
      .cmp_operation(cmp_operation), .cmp_res(cmp_res), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc), .br_err(br_err),
      .stat_branches(stat_branches), .stat_taken(stat_taken)
   );

   // External equality comparator
   assign cmp_res = (cmp_op1 == cmp_op2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, id, act, exp);
      end
   endtask

   // Monitor: one expected record per cycle, compared away from the clock edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", e.id, {31'd0, stall}, {31'd0, e.stall});
            chk("redirect", e.id, {31'd0, redirect}, {31'd0, e.redir});
            chk("redirect_pc", e.id, redirect_pc, e.pc);
            chk("br_err", e.id, {31'd0, br_err}, {31'd0, e.err});
            chk("cmp_operation", e.id, {29'd0, cmp_operation}, 32'd0);
         end
      end
   end

   task automatic cyc(input logic rst, input logic v, input logic [2:0] ty,
                      input logic [31:0] pc, input logic [31:0] off,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic rsp, input logic rtp, input logic k,
                      input logic es, input logic er, input logic [31:0] epc,
                      input logic ee);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n      = rst;
      br_valid   = v;
      br_type    = ty;
      pc_plus4   = pc;
      br_offset  = off;
      rs_data    = rs;
      rt_data    = rt;
      rs_pending = rsp;
      rt_pending = rtp;
      kill       = k;
      e.id = cyc_id; e.stall = es; e.redir = er; e.pc = epc; e.err = ee;
      exp_q.push_back(e);
      cyc_id++;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
   endtask

   initial begin
      rst_n = 1'b0; br_valid = 1'b0; br_type = 3'd0; pc_plus4 = 32'd0;
      br_offset = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
      rs_pending = 1'b0; rt_pending = 1'b0; kill = 1'b0;

      // Reset held with a branch presented: everything quiet
      cyc(1'b0, 1'b1, 3'd0, 32'h100, 32'h10, 32'h1234, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b1, 3'd0, 32'h100, 32'h10, 32'h1234, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      // BEQ taken, target 0x100 + 0x40
      cyc(1'b1, 1'b1, 3'd0, 32'h100, 32'h10, 32'h1234, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 1'b1, 3'd0, 32'h100, 32'h10, 32'h1234, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h140, 1'b0);
      // BNE equal -> not taken; back-to-back BGEZ rs=0, offset -1 -> 0x2FC
      cyc(1'b1, 1'b1, 3'd1, 32'h200, 32'h4, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h140, 1'b0);
      cyc(1'b1, 1'b1, 3'd1, 32'h200, 32'h4, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h140, 1'b0);
      cyc(1'b1, 1'b1, 3'd5, 32'h300, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h140, 1'b0);
      cyc(1'b1, 1'b1, 3'd5, 32'h300, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2FC, 1'b0);
      // BGTZ negative rs, rs pending 3 cycles, rt_pending ignored -> 4 stall cycles, not taken
      cyc(1'b1, 1'b1, 3'd3, 32'h400, 32'h8, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2FC, 1'b0);
      cyc(1'b1, 1'b1, 3'd3, 32'h400, 32'h8, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2FC, 1'b0);
      cyc(1'b1, 1'b1, 3'd3, 32'h400, 32'h8, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2FC, 1'b0);
      cyc(1'b1, 1'b1, 3'd3, 32'h400, 32'h8, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2FC, 1'b0);
      cyc(1'b1, 1'b1, 3'd3, 32'h400, 32'h8, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2FC, 1'b0);
      // BLEZ rs=0 (rt nonzero must not reach the comparator) -> taken, 0x504
      cyc(1'b1, 1'b1, 3'd2, 32'h500, 32'h1, 32'h0, 32'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2FC, 1'b0);
      cyc(1'b1, 1'b1, 3'd2, 32'h500, 32'h1, 32'h0, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h504, 1'b0);
      // BEQ killed in EVAL
      cyc(1'b1, 1'b1, 3'd0, 32'h600, 32'h2, 32'h7, 32'h7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h504, 1'b0);
      cyc(1'b1, 1'b1, 3'd0, 32'h600, 32'h2, 32'h7, 32'h7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h504, 1'b0);
      // BNE waiting on rt, killed in WAIT -> IDLE next cycle
      cyc(1'b1, 1'b1, 3'd1, 32'h700, 32'h0, 32'h1, 32'h2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h504, 1'b0);
      cyc(1'b1, 1'b1, 3'd1, 32'h700, 32'h0, 32'h1, 32'h2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h504, 1'b0);
      cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h504, 1'b0);
      // Kill in IDLE suppresses capture; next cycle captures
      cyc(1'b1, 1'b1, 3'd0, 32'h800, 32'h0, 32'h3, 32'h3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h504, 1'b0);
      cyc(1'b1, 1'b1, 3'd0, 32'h800, 32'h0, 32'h3, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h504, 1'b0);
      cyc(1'b1, 1'b1, 3'd0, 32'h800, 32'h0, 32'h3, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h800, 1'b0);
      // Invalid type 111: single br_err pulse, no redirect
      cyc(1'b1, 1'b1, 3'd7, 32'h900, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h800, 1'b0);
      cyc(1'b1, 1'b1, 3'd7, 32'h900, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h800, 1'b1);
      cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h800, 1'b0);
      // Reset asserted mid-WAIT: stall drops at once, state and redirect_pc cleared
      cyc(1'b1, 1'b1, 3'd0, 32'hA00, 32'h0, 32'h9, 32'h9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h800, 1'b0);
      cyc(1'b0, 1'b1, 3'd0, 32'hA00, 32'h0, 32'h9, 32'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      // Three branches after reset, two taken
      cyc(1'b1, 1'b1, 3'd0, 32'h40, 32'h1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 1'b1, 3'd0, 32'h40, 32'h1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
      cyc(1'b1, 1'b1, 3'd1, 32'h80, 32'h0, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 1'b0);
      cyc(1'b1, 1'b1, 3'd1, 32'h80, 32'h0, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
      cyc(1'b1, 1'b1, 3'd0, 32'hC0, 32'h0, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 1'b0);
      cyc(1'b1, 1'b1, 3'd0, 32'hC0, 32'h0, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 1'b0);
      cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 1'b0);
      drain();

`ifdef BRANCH_UNIT_STATS_EN
      chk("stat_branches", cyc_id, stat_branches, 32'd3);
      chk("stat_taken", cyc_id, stat_taken, 32'd2);
      force dut.stat_branches_q = 32'hFFFF_FFFE;
      force dut.stat_taken_q    = 32'hFFFF_FFFE;
      #1;
      release dut.stat_branches_q;
      release dut.stat_taken_q;
      cyc(1'b1, 1'b1, 3'd0, 32'hC0, 32'h0, 32'h4, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 1'b0);
      cyc(1'b1, 1'b1, 3'd0, 32'hC0, 32'h0, 32'h4, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC0, 1'b0);
      cyc(1'b1, 1'b1, 3'd0, 32'hC0, 32'h0, 32'h4, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC0, 1'b0);
      cyc(1'b1, 1'b1, 3'd0, 32'hC0, 32'h0, 32'h4, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC0, 1'b0);
      cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC0, 1'b0);
      drain();
      chk("stat_branches_sat", cyc_id, stat_branches, 32'hFFFF_FFFF);
      chk("stat_taken_sat", cyc_id, stat_taken, 32'hFFFF_FFFF);
`else
      chk("stat_branches_tied", cyc_id, stat_branches, 32'd0);
      chk("stat_taken_tied", cyc_id, stat_taken, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
